// File: rtl/jtag_master_shifter.sv
// rtl/jtag_master_shifter.sv - JTAG initiator engine: TAP reset, IR/DR scan and idle clocking
module jtag_master_shifter #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_len,
    input  logic [31:0] cmd_tdi,
    output logic        rsp_valid,
    output logic [31:0] rsp_tdo,
    output logic        busy,
    output logic        tck_o,
    output logic        tms_o,
    output logic        tdi_o,
    input  logic        tdo_i
);
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_SHIFT, S_TAIL, S_DONE} state_t;

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_IR    = 2'b01;
    localparam logic [1:0] OP_DR    = 2'b10;
    localparam logic [1:0] OP_IDLE  = 2'b11;

    localparam logic [8:0] CNT_LAST = 9'(2 * CLK_DIV - 1);
    localparam logic [8:0] CNT_RISE = 9'(CLK_DIV);

    state_t      state, state_nxt;
    logic [1:0]  op_q;
    logic [4:0]  len_q;
    logic [31:0] tdi_q;
    logic [31:0] tdo_q;
    logic [4:0]  idx, idx_nxt;
    logic        fin, fin_nxt;
    logic [8:0]  cnt;
    logic        accept, active, fall, rise, scan_op, tms_val;
    logic [2:0]  hdr_last;
    logic [7:0]  hdr_pat;

    assign accept    = cmd_valid && (state == S_IDLE);
    assign active    = (state == S_HDR) || (state == S_SHIFT) || (state == S_TAIL);
    assign fall      = active && (cnt == 9'd0);
    assign rise      = active && (cnt == CNT_RISE);
    assign scan_op   = (op_q == OP_IR) || (op_q == OP_DR);
    assign busy      = (state != S_IDLE);
    assign cmd_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_DONE);

    // Header TMS pattern, bit i = TMS of header TCK i
    always_comb begin
        hdr_last = 3'd2;
        hdr_pat  = 8'b0000_0001;
        case (op_q)
            OP_RESET: begin
                hdr_last = 3'd5;
                hdr_pat  = 8'b0001_1111;
            end
            OP_IR: begin
                hdr_last = 3'd3;
                hdr_pat  = 8'b0000_0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        tms_val = 1'b1;
        case (state)
            S_HDR:   tms_val = hdr_pat[idx[2:0]];
            S_SHIFT: tms_val = scan_op && (idx == len_q);
            S_TAIL:  tms_val = (idx == 5'd0);
            default: ;
        endcase
    end

    // idx/state advance on the TCK rising edge; fin marks that the TCK in flight is the last one
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        fin_nxt   = fin;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_nxt = (cmd_op == OP_IDLE) ? S_SHIFT : S_HDR;
                    idx_nxt   = 5'd0;
                    fin_nxt   = 1'b0;
                end
            end
            S_HDR: begin
                if (rise) begin
                    if (idx == {2'b00, hdr_last}) begin
                        if (op_q == OP_RESET) begin
                            fin_nxt = 1'b1;
                        end else begin
                            state_nxt = S_SHIFT;
                            idx_nxt   = 5'd0;
                        end
                    end else begin
                        idx_nxt = idx + 5'd1;
                    end
                end
            end
            S_SHIFT: begin
                if (rise) begin
                    if (idx == len_q) begin
                        if (op_q == OP_IDLE) begin
                            fin_nxt = 1'b1;
                        end else begin
                            state_nxt = S_TAIL;
                            idx_nxt   = 5'd0;
                        end
                    end else begin
                        idx_nxt = idx + 5'd1;
                    end
                end
            end
            S_TAIL: begin
                if (rise) begin
                    if (idx == 5'd1) begin
                        fin_nxt = 1'b1;
                    end else begin
                        idx_nxt = idx + 5'd1;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (fall && fin) begin
            state_nxt = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx     <= 5'd0;
            fin     <= 1'b0;
            cnt     <= 9'd0;
            op_q    <= 2'b00;
            len_q   <= 5'd0;
            tdi_q   <= 32'd0;
            tdo_q   <= 32'd0;
            tck_o   <= 1'b0;
            tms_o   <= 1'b1;
            tdi_o   <= 1'b1;
            rsp_tdo <= 32'd0;
        end else begin
            idx <= idx_nxt;
            fin <= fin_nxt;
            if (accept) begin
                op_q  <= cmd_op;
                len_q <= cmd_len;
                tdi_q <= cmd_tdi;
                tdo_q <= 32'd0;
                cnt   <= 9'd0;
            end else if (active) begin
                cnt <= (cnt == CNT_LAST) ? 9'd0 : cnt + 9'd1;
            end
            if (fall) begin
                tck_o <= 1'b0;
                if (fin) begin
                    tdi_o   <= 1'b1;
                    rsp_tdo <= tdo_q;
                end else begin
                    tms_o <= tms_val;
                    tdi_o <= (state == S_SHIFT) ? tdi_q[idx] : 1'b1;
                end
            end
            if (rise) begin
                tck_o <= 1'b1;
                if ((state == S_SHIFT) && scan_op) begin
                    tdo_q[idx] <= tdo_i;
                end
            end
        end
    end
endmodule

// File: tb/tb_jtag_master_shifter.sv
// tb/tb_jtag_master_shifter.sv - scoreboard bench for jtag_master_shifter with loopback and TAP model
module tb_jtag_master_shifter;
    localparam int D = 2;
    localparam logic [31:0] IDCODE = 32'h1DEA_D0F3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [4:0]  cmd_len = 5'd0;
    logic [31:0] cmd_tdi = 32'd0;
    logic        cmd_ready, rsp_valid, busy, tck_o, tms_o, tdi_o, tdo_i;
    logic [31:0] rsp_tdo;
    logic [1:0]  tdo_mode = 2'd2;

    jtag_master_shifter #(.CLK_DIV(D)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_tdi   (cmd_tdi),
        .rsp_valid (rsp_valid),
        .rsp_tdo   (rsp_tdo),
        .busy      (busy),
        .tck_o     (tck_o),
        .tms_o     (tms_o),
        .tdi_o     (tdi_o),
        .tdo_i     (tdo_i)
    );

    always #5 clk = ~clk;

    // Behavioural target TAP: IR width 5, capture 00001, DR always IDCODE
    typedef enum logic [3:0] {TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
                              SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_t;
    tap_t        tap = TLR;
    logic [31:0] tap_dr = 32'd0;
    logic [4:0]  tap_ir = 5'd0;
    logic        tap_tdo = 1'b0;

    function automatic tap_t tap_next(input tap_t s, input logic t);
        case (s)
            TLR:     return t ? TLR  : RTI;
            RTI:     return t ? SDR  : RTI;
            SDR:     return t ? SIR  : CDR;
            CDR:     return t ? E1DR : SHDR;
            SHDR:    return t ? E1DR : SHDR;
            E1DR:    return t ? UDR  : PDR;
            PDR:     return t ? E2DR : PDR;
            E2DR:    return t ? UDR  : SHDR;
            UDR:     return t ? SDR  : RTI;
            SIR:     return t ? TLR  : CIR;
            CIR:     return t ? E1IR : SHIR;
            SHIR:    return t ? E1IR : SHIR;
            E1IR:    return t ? UIR  : PIR;
            PIR:     return t ? E2IR : PIR;
            E2IR:    return t ? UIR  : SHIR;
            default: return t ? SDR  : RTI;
        endcase
    endfunction

    always @(posedge tck_o) begin
        if (tap == CDR) tap_dr <= IDCODE;
        else if (tap == SHDR) tap_dr <= {tdi_o, tap_dr[31:1]};
        if (tap == CIR) tap_ir <= 5'b00001;
        else if (tap == SHIR) tap_ir <= {tdi_o, tap_ir[4:1]};
        tap <= tap_next(tap, tms_o);
    end

    always @(negedge tck_o) tap_tdo <= (tap == SHIR) ? tap_ir[0] : tap_dr[0];

    assign tdo_i = (tdo_mode == 2'd1) ? tdi_o : (tdo_mode == 2'd2) ? tap_tdo : 1'b0;

    typedef struct {
        logic [31:0] tdo;
        logic [63:0] tms;
        int          ntck;
        int          lat;
        bit          ones;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0, n_pass = 0, n_push = 0, n_rsp = 0;
    int   cyc = 0, tck_total = 0, tck_start = 0, acc_cyc = 0, ready_run = 0, mon_n = 0;
    bit   b2b_armed = 1'b0;
    bit   mon_ones;
    logic [63:0] mon_tms;
    logic tms_hist [4096];
    logic tdi_hist [4096];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge tck_o) begin
        tms_hist[tck_total % 4096] = tms_o;
        tdi_hist[tck_total % 4096] = tdi_o;
        tck_total = tck_total + 1;
    end

    always @(negedge clk) begin
        if (rsp_valid) begin
            n_rsp++;
            ready_run = 0;
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_rsp: rsp_valid with rsp_tdo=%0h but no command pending", rsp_tdo);
            end else begin
                mon_e = sb.pop_front();
                mon_n = tck_total - tck_start;
                mon_tms = 64'd0;
                mon_ones = 1'b1;
                for (int i = 0; i < mon_n && i < 64; i++) begin
                    mon_tms[i] = tms_hist[(tck_start + i) % 4096];
                    if (!tdi_hist[(tck_start + i) % 4096]) mon_ones = 1'b0;
                end
                check("rsp_tdo", 64'(rsp_tdo), 64'(mon_e.tdo));
                check("tck_count", 64'(mon_n), 64'(mon_e.ntck));
                check("tms_seq", mon_tms, mon_e.tms);
                check("rsp_latency", 64'(cyc - acc_cyc), 64'(mon_e.lat));
                check("tap_end_rti", 64'(tap), 64'(RTI));
                if (mon_e.ones) check("tdi_held_high", 64'(mon_ones), 64'd1);
            end
        end else if (cmd_ready) begin
            ready_run++;
            if (cmd_valid) begin
                if (b2b_armed) check("b2b_ready_gap", 64'(ready_run), 64'd1);
                acc_cyc = cyc + 1;
                tck_start = tck_total;
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [4:0] len, input logic [31:0] tdi,
                         input logic [31:0] etdo, input logic [63:0] etms, input int entck,
                         input int elat, input bit eones, input bit push);
        exp_t e;
        int w;
        if (push) begin
            e.tdo = etdo; e.tms = etms; e.ntck = entck; e.lat = elat; e.ones = eones;
            sb.push_back(e);
            n_push++;
        end
        cmd_op = op; cmd_len = len; cmd_tdi = tdi; cmd_valid = 1'b1;
        for (w = 0; w < 1000; w++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        if (w == 1000) begin
            n_chk++;
            $display("FAIL accept_timeout: cmd_ready stayed low for %0d cycles", w);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int w;
        for (w = 0; w < 2000; w++) begin
            @(negedge clk);
            if (n_rsp == n_push) break;
        end
        if (w == 2000) begin
            n_chk++;
            $display("FAIL rsp_timeout: got %0d responses expected %0d", n_rsp, n_push);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [1:0] op, input logic [4:0] len, input logic [31:0] tdi,
                       input logic [31:0] etdo, input logic [63:0] etms, input int entck,
                       input int elat, input bit eones);
        issue(op, len, tdi, etdo, etms, entck, elat, eones, 1'b1);
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom);
        cmd_len = 5'($urandom);
        cmd_tdi = $urandom;
        wait_done();
    endtask

    initial begin
        int w;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tck", 64'(tck_o), 64'd0);
        check("rst_tms", 64'(tms_o), 64'd1);
        check("rst_tdi", 64'(tdi_o), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_tdo", 64'(rsp_tdo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        tdo_mode = 2'd2;
        run(2'b00, 5'd0,  32'h0000_0000, 32'h0,        64'h1F,           6,  25,  1'b1);
        run(2'b01, 5'd4,  32'h0000_0001, 32'h1,        64'h303,          11, 45,  1'b0);
        run(2'b10, 5'd31, 32'h0000_0000, IDCODE,       64'hC_0000_0001,  37, 149, 1'b0);

        tdo_mode = 2'd1;
        run(2'b10, 5'd31, 32'hA5C3_0F96, 32'hA5C3_0F96, 64'hC_0000_0001, 37, 149, 1'b0);
        run(2'b10, 5'd0,  32'h0000_0001, 32'h1,        64'h19,           6,  25,  1'b0);
        run(2'b11, 5'd9,  32'h0000_03FF, 32'h0,        64'h0,            10, 41,  1'b0);

        issue(2'b10, 5'd7, 32'hFFFF_FF5A, 32'h5A, 64'hC01, 13, 53, 1'b0, 1'b1);
        b2b_armed = 1'b1;
        issue(2'b01, 5'd2, 32'h1234_5675, 32'h5,  64'hC3,  9,  37, 1'b0, 1'b1);
        issue(2'b11, 5'd0, 32'hFFFF_FFFF, 32'h0,  64'h0,   1,  5,  1'b0, 1'b1);
        b2b_armed = 1'b0;
        cmd_valid = 1'b0;
        wait_done();

        issue(2'b10, 5'd31, 32'hFFFF_FFFF, 32'h0, 64'h0, 0, 0, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        for (w = 0; w < 500; w++) begin
            @(negedge clk);
            if (tck_total - tck_start >= 11) break;
        end
        if (w == 500) begin
            n_chk++;
            $display("FAIL abort_wait: only %0d TCKs seen", tck_total - tck_start);
        end
        reset_n = 1'b0;
        #1;
        check("abort_tck", 64'(tck_o), 64'd0);
        check("abort_tms", 64'(tms_o), 64'd1);
        check("abort_tdi", 64'(tdi_o), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        @(posedge clk);
        #1;
        run(2'b00, 5'd0, 32'h0, 32'h0, 64'h1F, 6, 25, 1'b1);

        check("sb_empty", 64'(sb.size()), 64'd0);
        check("rsp_count", 64'(n_rsp), 64'(n_push));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/jtag_master_shifter.md
# jtag_master_shifter

JTAG initiator engine that drives a target TAP through TCK/TMS/TDI and samples TDO. It executes one command at a time: TAP reset, IR scan, DR scan or idle clocking. Each command comes in through a valid/ready port and returns one response carrying the captured TDO bits. The SoC debug/test path uses it to drive the JTAG pins of a companion rv32i SoC die, or to loop back into our own JTAG pads in a self-test configuration.

## Interface
- CLK_DIV, 4: TCK half-period in clk cycles; legal range 2..255.
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine can accept a command.
- cmd_op  in  2  operation select:
  - 00: TAP reset.
  - 01: IR scan.
  - 10: DR scan.
  - 11: idle clocks.
- cmd_len  in  5  bit count minus 1 (1..32 bits or TCKs); ignored for op 00.
- cmd_tdi  in  32  scan data, shifted out LSB first.
- rsp_valid  out  1  one-cycle pulse at command completion.
- rsp_tdo  out  32  captured TDO, LSB = first bit shifted; held until the next rsp_valid.
- busy  out  1  a command is in progress.
- tck_o  out  1  JTAG TCK.
- tms_o  out  1  JTAG TMS.
- tdi_o  out  1  JTAG TDI.
- tdo_i  in  1  JTAG TDO from the target; synchronous to tck_o.

## Operation
- The engine assumes the target TAP is in Run-Test/Idle (RTI) between commands. Software issues op 00 first after power-up.
- States:
  - IDLE: cmd_ready=1. Leaves on cmd_valid&&cmd_ready.
  - HDR: header TCKs.
  - SHIFT: N=cmd_len+1 TCKs.
  - TAIL: trailer TCKs.
  - DONE: one cycle; pulses rsp_valid and returns to IDLE.
- The command is latched at acceptance. Input changes during busy are ignored.
- TMS sequence per op (one value per TCK):
  - Reset: HDR = 1,1,1,1,1,0 (6 TCKs). No SHIFT, no TAIL.
  - IR scan: HDR = 1,1,0,0 (RTI→SelDR→SelIR→CapIR→ShiftIR). SHIFT has TMS=0 on bits 0..N-2 and TMS=1 on bit N-1 (→Exit1). TAIL = 1,0 (Update→RTI). Total N+6 TCKs.
  - DR scan: HDR = 1,0,0. SHIFT is the same as IR scan. TAIL = 1,0. Total N+5 TCKs.
  - Idle: SHIFT only, N TCKs with TMS=0.
- tdi_o:
  - During SHIFT bit i: cmd_tdi[i].
  - Outside SHIFT: held at 1.
- rsp_tdo:
  - Bit i = tdo_i sampled during SHIFT bit i.
  - Bits ≥ N = 0.
  - Ops 00 and 11 return 0.
- busy = (state != IDLE). cmd_ready = (state == IDLE).

## Timing
- Reset values:
  - tck_o=0, tms_o=1, tdi_o=1.
  - rsp_valid=0, rsp_tdo=0, busy=0, cmd_ready=1.
  - State = IDLE.
- Reset asserted mid-command aborts the command immediately. No rsp_valid is produced. tck_o drops to 0 asynchronously.
- TCK period = 2*CLK_DIV clk cycles, low phase first.
- Cycle numbering: cycle 0 is the acceptance edge. TCK k (k=0..K-1):
  - Low phase: cycles 2kD+1 .. 2kD+D, where D=CLK_DIV.
  - High phase: cycles 2kD+D+1 .. 2kD+2D.
- tms_o and tdi_o update on the clk edge that begins each low phase. They are stable through the following rising edge of tck_o.
- tdo_i is sampled on the clk edge that raises tck_o. The target launches TDO on the falling edge, so it is stable there.
- tck_o is registered: it has no glitches, and its duty cycle is exactly 50%.
- rsp_valid pulses in cycle 2KD+1 (DONE), where K = total TCKs.
- cmd_ready returns high the cycle after DONE. Command-to-command gap is one idle clk cycle plus the acceptance edge.
- Boundaries:
  - cmd_len=0 gives a 1-bit scan, where TMS=1 on the only shift bit.
  - cmd_len=31 gives a full 32-bit scan with no truncation.
  - cmd_valid held continuously produces back-to-back commands with no dropped responses.
  - rsp_valid is never suppressed; there is no response backpressure.

## Test plan
- Reset op, CLK_DIV=2: 6 TCKs with TMS 1,1,1,1,1,0. rsp_valid pulses at cycle 25 with rsp_tdo=0. tdi_o stays 1 throughout.
- Loopback (tdo_i wired to tdi_o), DR scan, cmd_len=31, cmd_tdi=0xA5C3_0F96: 37 TCKs; TMS = 1,0,0, then 31 zeros, then 1,1,0. rsp_tdo=0xA5C3_0F96.
- Behavioural TAP model with IDCODE 0x1DEA_D0F3 and IR width 5. Sequence: reset, then IR scan (cmd_len=4, cmd_tdi=0x01), then DR scan (cmd_len=31). Results:
  - IR scan rsp_tdo[4:0]=5'b00001 (capture pattern).
  - DR scan rsp_tdo=0x1DEA_D0F3.
  - Model ends in RTI after each command.
- Loopback, cmd_len=0, cmd_tdi=1: DR scan with TMS = 1,0,0,1,1,0 gives rsp_tdo=0x1. Idle op with cmd_len=9 gives 10 TCKs at TMS=0 and rsp_tdo=0.
- cmd_valid held high with 3 queued commands: three rsp_valid pulses, each followed by exactly one cycle of cmd_ready before the next acceptance.
- reset_n low during SHIFT bit 7 of a 32-bit DR scan: tck_o=0, tms_o=1 and busy=0 immediately; no rsp_valid. A subsequent reset op completes normally.
